// File: rtl/clz_pipe.sv
// clz_pipe: two-stage pipelined leading-zero / leading-one counter with valid/ready
// handshake, flush and tag sideband. Define CLZ_PIPE_CLO_EN to enable CLO via in_mode.
module clz_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 5,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NS = WIDTH / CHUNK;
    localparam int LW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    // Leading zeros within one slice; result is don't-care for an all-zero slice.
    function automatic logic [LW-1:0] slice_lz(input logic [CHUNK-1:0] s);
        logic [LW-1:0] r;
        logic          found;
        r     = '0;
        found = 1'b0;
        for (int b = CHUNK - 1; b >= 0; b--) begin
            if (!found && s[b]) begin
                r     = LW'(CHUNK - 1 - b);
                found = 1'b1;
            end else begin
                r     = r;
                found = found;
            end
        end
        return r;
    endfunction

    logic [WIDTH-1:0] x_s;
`ifdef CLZ_PIPE_CLO_EN
    assign x_s = in_mode ? ~in_data : in_data;
`else
    logic mode_unused_s;
    assign mode_unused_s = in_mode;
    assign x_s           = in_data;
`endif

    logic [NS-1:0]         nz_s;
    logic [NS-1:0][LW-1:0] lz_s;

    // Slice analysis of the incoming operand; index 0 is the most-significant slice.
    always_comb begin
        nz_s = '0;
        lz_s = '0;
        for (int i = 0; i < NS; i++) begin
            nz_s[i] = |x_s[WIDTH-1-i*CHUNK -: CHUNK];
            lz_s[i] = slice_lz(x_s[WIDTH-1-i*CHUNK -: CHUNK]);
        end
    end

    logic                  s1_valid_r;
    logic                  s2_valid_r;
    logic [NS-1:0]         s1_nz_r;
    logic [NS-1:0][LW-1:0] s1_lz_r;
    logic [TAG_W-1:0]      s1_tag_r;
    logic [CW-1:0]         s2_count_r;
    logic                  s2_all_r;
    logic [TAG_W-1:0]      s2_tag_r;
    logic                  s2_load_s;
    logic                  in_fire_s;
    logic                  out_fire_s;

    assign s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
    assign in_ready   = !s1_valid_r || s2_load_s;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = s2_valid_r && out_ready;

    assign out_valid = s2_valid_r;
    assign out_count = s2_count_r;
    assign out_all   = s2_all_r;
    assign out_tag   = s2_tag_r;

    // Stage occupancy; flush wins over any simultaneous load or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (in_fire_s) begin
                s1_valid_r <= 1'b1;
            end else if (s2_load_s) begin
                s1_valid_r <= 1'b0;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
            end else if (out_fire_s) begin
                s2_valid_r <= 1'b0;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
        end
    end

    // Stage-1 payload: per-slice flags and counts plus tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_nz_r  <= '0;
            s1_lz_r  <= '0;
            s1_tag_r <= '0;
        end else if (in_fire_s && !flush) begin
            s1_nz_r  <= nz_s;
            s1_lz_r  <= lz_s;
            s1_tag_r <= in_tag;
        end else begin
            s1_nz_r  <= s1_nz_r;
            s1_lz_r  <= s1_lz_r;
            s1_tag_r <= s1_tag_r;
        end
    end

    logic [CW-1:0] cnt_s;
    logic          all_s;

    // Priority select of the first nonzero slice; the MSB slice wins by iterating downwards.
    always_comb begin
        cnt_s = CW'(WIDTH);
        all_s = 1'b1;
        for (int i = NS - 1; i >= 0; i--) begin
            if (s1_nz_r[i]) begin
                cnt_s = CW'(i * CHUNK) + CW'(s1_lz_r[i]);
                all_s = 1'b0;
            end else begin
                cnt_s = cnt_s;
                all_s = all_s;
            end
        end
    end

    // Stage-2 result register; holds steady while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_count_r <= '0;
            s2_all_r   <= 1'b0;
            s2_tag_r   <= '0;
        end else if (s2_load_s && !flush) begin
            s2_count_r <= cnt_s;
            s2_all_r   <= all_s;
            s2_tag_r   <= s1_tag_r;
        end else begin
            s2_count_r <= s2_count_r;
            s2_all_r   <= s2_all_r;
            s2_tag_r   <= s2_tag_r;
        end
    end

endmodule

// File: tb/tb_clz_pipe.sv
// Self-checking bench for clz_pipe: vector table, back-pressure, flush, reset and a 64-bit instance.
module tb_clz_pipe;
    typedef struct packed {
        logic [31:0] data;
        logic        mode;
        logic [4:0]  tag;
        logic [5:0]  cnt;
        logic        all;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic [6:0]  cnt;
        logic        all;
    } v64_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, in_mode, out_valid, out_ready, out_all;
    logic [31:0] in_data;
    logic [4:0]  in_tag, out_tag;
    logic [5:0]  out_count;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_all;
    logic [63:0] w_in_data;
    logic [4:0]  w_in_tag, w_out_tag;
    logic [6:0]  w_out_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    vec_t exp_q[$];
    logic        prev_stalled = 1'b0;
    logic [5:0]  prev_count;
    logic        prev_all;
    logic [4:0]  prev_tag;

    always #5 clk = ~clk;

    clz_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_all(out_all), .out_tag(out_tag)
    );

    clz_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_mode(1'b0), .in_tag(w_in_tag),
        .out_valid(w_out_valid), .out_ready(1'b1),
        .out_count(w_out_count), .out_all(w_out_all), .out_tag(w_out_tag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at the negedge, then check output transfers and stall stability.
    task automatic cycle_step(input logic v, input vec_t vin, input logic ordy,
                              input logic fl, output logic acc);
        vec_t e;
        @(negedge clk);
        flush     = fl;
        out_ready = ordy;
        in_valid  = v;
        in_data   = vin.data;
        in_mode   = vin.mode;
        in_tag    = vin.tag;
        #1;
        if (prev_stalled && out_valid) begin
            check("stall_count", out_count, prev_count);
            check("stall_all", out_all, prev_all);
            check("stall_tag", out_tag, prev_tag);
        end
        if (out_valid && out_ready && !fl) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("count", out_count, e.cnt);
                check("all", out_all, e.all);
                check("tag", out_tag, e.tag);
                n_out++;
            end
        end
        prev_stalled = out_valid && !out_ready;
        prev_count   = out_count;
        prev_all     = out_all;
        prev_tag     = out_tag;
        acc = v && in_ready && !fl;
        if (acc) exp_q.push_back(vin);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        vec_t bp[4];
        vec_t fv[5];
        v64_t w[5];
        vec_t idle_v;
        logic acc;
        int   idx, base;

        vecs[0]  = '{32'h0000_0001, 1'b0, 5'd1,  6'd31, 1'b0};
        vecs[1]  = '{32'h8000_0000, 1'b0, 5'd2,  6'd0,  1'b0};
        vecs[2]  = '{32'h0000_0000, 1'b0, 5'd3,  6'd32, 1'b1};
        vecs[3]  = '{32'h0010_0000, 1'b0, 5'd4,  6'd11, 1'b0};
`ifdef CLZ_PIPE_CLO_EN
        vecs[4]  = '{32'hFFFF_0000, 1'b1, 5'd5,  6'd16, 1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 1'b1, 5'd6,  6'd32, 1'b1};
        vecs[6]  = '{32'h7FFF_FFFF, 1'b1, 5'd7,  6'd0,  1'b0};
        vecs[7]  = '{32'h0000_0000, 1'b1, 5'd8,  6'd0,  1'b0};
`else
        vecs[4]  = '{32'hFFFF_0000, 1'b1, 5'd5,  6'd0,  1'b0};
        vecs[5]  = '{32'hFFFF_FFFF, 1'b1, 5'd6,  6'd0,  1'b0};
        vecs[6]  = '{32'h7FFF_FFFF, 1'b1, 5'd7,  6'd1,  1'b0};
        vecs[7]  = '{32'h0000_0000, 1'b1, 5'd8,  6'd32, 1'b1};
`endif
        vecs[8]  = '{32'h00FF_0000, 1'b0, 5'd9,  6'd8,  1'b0};
        vecs[9]  = '{32'h0000_0080, 1'b0, 5'd10, 6'd24, 1'b0};
        vecs[10] = '{32'h0000_8000, 1'b0, 5'd11, 6'd16, 1'b0};
        vecs[11] = '{32'h0000_007F, 1'b0, 5'd12, 6'd25, 1'b0};

        bp[0] = '{32'h0000_0100, 1'b0, 5'd1, 6'd23, 1'b0};
        bp[1] = '{32'h0001_0000, 1'b0, 5'd2, 6'd15, 1'b0};
        bp[2] = '{32'h4000_0000, 1'b0, 5'd3, 6'd1,  1'b0};
        bp[3] = '{32'h0000_0000, 1'b0, 5'd4, 6'd32, 1'b1};

        fv[0] = '{32'h0000_0F00, 1'b0, 5'd20, 6'd20, 1'b0};
        fv[1] = '{32'h0000_0003, 1'b0, 5'd21, 6'd30, 1'b0};
        fv[2] = '{32'h0200_0000, 1'b0, 5'd22, 6'd6,  1'b0};
        fv[3] = '{32'h0000_0040, 1'b0, 5'd23, 6'd25, 1'b0};
        fv[4] = '{32'h0004_0000, 1'b0, 5'd24, 6'd13, 1'b0};

        w[0] = '{64'h0000_0000_0000_0100, 7'd55, 1'b0};
        w[1] = '{64'h0000_0000_0000_0000, 7'd64, 1'b1};
        w[2] = '{64'h8000_0000_0000_0000, 7'd0,  1'b0};
        w[3] = '{64'h0000_8000_0000_0000, 7'd16, 1'b0};
        w[4] = '{64'h0000_0000_0001_0000, 7'd47, 1'b0};

        idle_v = '0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        in_tag = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_data = '0; w_in_tag = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_count", out_count, 6'd0);
        check("rst_out_all", out_all, 1'b0);
        check("rst_out_tag", out_tag, 5'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Back-to-back table stream: result c-2 must be visible at cycle c.
        for (int c = 0; c < 14; c++) begin
            cycle_step(c < 12, (c < 12) ? vecs[c] : idle_v, 1'b1, 1'b0, acc);
            check("stream_in_ready", in_ready, 1'b1);
            check("stream_out_valid", out_valid, (c >= 2) ? 1'b1 : 1'b0);
        end
        cycle_step(1'b0, idle_v, 1'b1, 1'b0, acc);
        check("stream_drained", exp_q.size(), 0);

        // Back-pressure: four cycles with out_ready low, tags 1..4 offered.
        base = n_out;
        idx  = 0;
        for (int cyc = 0; cyc < 20 && (n_out - base) < 4; cyc++) begin
            cycle_step(idx < 4, (idx < 4) ? bp[idx] : idle_v, (cyc >= 4) ? 1'b1 : 1'b0, 1'b0, acc);
            if (acc) idx++;
            if (cyc == 2) check("bp_in_ready_full", in_ready, 1'b0);
            if (cyc == 3) check("bp_accepted", idx, 2);
            if (cyc == 4) check("bp_in_ready_passthru", in_ready, 1'b1);
        end
        check("bp_all_out", n_out - base, 4);
        check("bp_queue_empty", exp_q.size(), 0);

        // Flush with both stages full and a new operand presented.
        cycle_step(1'b1, fv[0], 1'b0, 1'b0, acc);
        cycle_step(1'b1, fv[1], 1'b0, 1'b0, acc);
        cycle_step(1'b1, fv[2], 1'b0, 1'b1, acc);
        exp_q.delete();
        prev_stalled = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle_step(1'b0, idle_v, 1'b1, 1'b0, acc);
            check("flush_out_valid", out_valid, 1'b0);
        end
        // Flush with the unit ready: the operand must still be dropped.
        cycle_step(1'b1, fv[3], 1'b1, 1'b1, acc);
        check("flush_in_ready", in_ready, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cycle_step(1'b0, idle_v, 1'b1, 1'b0, acc);
            check("flush2_out_valid", out_valid, 1'b0);
        end
        base = n_out;
        cycle_step(1'b1, fv[4], 1'b1, 1'b0, acc);
        for (int c = 0; c < 10 && n_out == base; c++) cycle_step(1'b0, idle_v, 1'b1, 1'b0, acc);
        check("post_flush_out", n_out - base, 1);

        // Reset mid-operation with both stages valid.
        cycle_step(1'b1, bp[0], 1'b0, 1'b0, acc);
        cycle_step(1'b1, bp[1], 1'b0, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_count", out_count, 6'd0);
        check("mid_rst_out_tag", out_tag, 5'd0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        prev_stalled = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle_step(1'b0, idle_v, 1'b1, 1'b0, acc);
            check("post_rst_out_valid", out_valid, 1'b0);
        end

        // 64-bit / 16-bit-chunk instance.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check("w64_valid", w_out_valid, 1'b1);
                check("w64_count", w_out_count, w[c-2].cnt);
                check("w64_all", w_out_all, w[c-2].all);
                check("w64_tag", w_out_tag, 5'(c - 2));
            end
            w_in_valid = (c < 5);
            w_in_data  = (c < 5) ? w[c].data : 64'd0;
            w_in_tag   = 5'(c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
